// File: rtl/anton_neopixel_stream_seq_pkg.sv
// Shared macros (state encodings, CLOG2, parameter defaults) and types for the neopixel sequencer.
// Optional feature macro used by the top: ANTON_NEOPIXEL_FRAME_COUNT_EN.
`ifndef ANTON_COMMON_VH
`define ANTON_COMMON_VH
`define ENUM_STATE_RESET      1'b0
`define ENUM_STATE_TRANSMIT   1'b1
`define CLOG2(x)              $clog2(x)
`define BUFFER_END_DEFAULT    255
`define RESET_CYCLES_DEFAULT  400
`endif

package anton_neopixel_stream_seq_pkg;

    typedef enum logic {
        ST_RESET    = `ENUM_STATE_RESET,
        ST_TRANSMIT = `ENUM_STATE_TRANSMIT
    } seq_state_e;

endpackage

// File: rtl/anton_neopixel_latch_timer.sv
// Latch-period up-counter: start clears it, enable advances it, done flags the final count.
module anton_neopixel_latch_timer #(
    parameter int RESET_CYCLES = `RESET_CYCLES_DEFAULT
) (
    input  logic clk7mhz,
    input  logic rst,
    input  logic start,
    input  logic enable,
    output logic done
);
    localparam int RST_BITS = `CLOG2(RESET_CYCLES + 1);
    localparam logic [RST_BITS-1:0] CNT_LAST = RST_BITS'(RESET_CYCLES - 1);

    logic [RST_BITS-1:0] cnt_q;
    logic [RST_BITS-1:0] cnt_d;

    // done is combinational so the sequencer can act on the same edge the count wraps
    assign done = enable && !start && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = done ? '0 : cnt_q + RST_BITS'(1);
        end
    end

    always_ff @(posedge clk7mhz) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/anton_neopixel_stream_seq.sv
// Neopixel frame sequencer: steps the pixel index during TRANSMIT and times the RESET latch gap.
// Define ANTON_NEOPIXEL_FRAME_COUNT_EN to add the 16-bit frame_count output.
module anton_neopixel_stream_seq
    import anton_neopixel_stream_seq_pkg::*;
#(
    parameter int BUFFER_END   = `BUFFER_END_DEFAULT,
    parameter int RESET_CYCLES = `RESET_CYCLES_DEFAULT,
    localparam int BUFFER_BITS = `CLOG2(BUFFER_END + 1)
) (
    input  logic                   clk7mhz,
    input  logic                   rst,
    input  logic                   reg_ctrl_init,
    input  logic                   reg_ctrl_run,
    input  logic                   reg_ctrl_loop,
    input  logic                   reg_ctrl_32bit,
    input  logic                   stream_bit_of,
    input  logic                   stream_pixel_of,
    output logic                   state,
`ifdef ANTON_NEOPIXEL_FRAME_COUNT_EN
    output logic [15:0]            frame_count,
`endif
    output logic [BUFFER_BITS-1:0] pixel_index,
    output logic                   frame_done,
    output logic                   run_clear
);
    seq_state_e             state_q, state_d;
    logic [BUFFER_BITS-1:0] idx_q, idx_d;
    logic                   frame_done_q, frame_done_d;
    logic                   run_clear_q, run_clear_d;
    logic                   active;
    logic                   timer_start;
    logic                   timer_done;
    logic [BUFFER_BITS-1:0] idx_base;
    logic [BUFFER_BITS-1:0] idx_step;

    assign active = reg_ctrl_run && !reg_ctrl_init;

    // 32-bit mode realigns to a word boundary so a mid-frame mode switch lands on a pixel start
    assign idx_base = reg_ctrl_32bit ? (idx_q & ~BUFFER_BITS'(3)) : idx_q;
    assign idx_step = reg_ctrl_32bit ? BUFFER_BITS'(4) : BUFFER_BITS'(1);

    anton_neopixel_latch_timer #(
        .RESET_CYCLES(RESET_CYCLES)
    ) u_latch_timer (
        .clk7mhz (clk7mhz),
        .rst     (rst),
        .start   (timer_start),
        .enable  (active && (state_q == ST_RESET)),
        .done    (timer_done)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        frame_done_d = 1'b0;
        run_clear_d  = 1'b0;
        timer_start  = 1'b0;
        if (reg_ctrl_init) begin
            state_d     = ST_RESET;
            idx_d       = '0;
            timer_start = 1'b1;
        end else if (active) begin
            case (state_q)
                ST_TRANSMIT: begin
                    if (stream_bit_of) begin
                        if (stream_pixel_of) begin
                            state_d     = ST_RESET;
                            idx_d       = '0;
                            timer_start = 1'b1;
                        end else begin
                            idx_d = idx_base + idx_step;
                        end
                    end
                end
                default: begin
                    if (timer_done) begin
                        frame_done_d = 1'b1;
                        if (reg_ctrl_loop) begin
                            state_d = ST_TRANSMIT;
                            idx_d   = '0;
                        end else begin
                            run_clear_d = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk7mhz) begin
        if (rst) begin
            state_q      <= ST_RESET;
            idx_q        <= '0;
            frame_done_q <= 1'b0;
            run_clear_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            frame_done_q <= frame_done_d;
            run_clear_q  <= run_clear_d;
        end
    end

`ifdef ANTON_NEOPIXEL_FRAME_COUNT_EN
    logic [15:0] frame_count_q, frame_count_d;

    assign frame_count_d = frame_done_d ? frame_count_q + 16'd1 : frame_count_q;

    always_ff @(posedge clk7mhz) begin
        if (rst) begin
            frame_count_q <= '0;
        end else begin
            frame_count_q <= frame_count_d;
        end
    end

    assign frame_count = frame_count_q;
`endif

    assign state       = state_q;
    assign pixel_index = idx_q;
    assign frame_done  = frame_done_q;
    assign run_clear   = run_clear_q;

endmodule

// File: tb/tb_anton_neopixel_stream_seq.sv
// Self-checking bench for anton_neopixel_stream_seq (BUFFER_END=7, RESET_CYCLES=400).
// Pixel advances are scored through an expected-value queue filled when stream_bit_of is driven.
module tb_anton_neopixel_stream_seq;
    localparam int BE = 7;
    localparam int RC = 400;

    logic       clk7mhz = 1'b0;
    logic       rst = 1'b1;
    logic       init = 1'b0;
    logic       run = 1'b0;
    logic       loop_en = 1'b0;
    logic       m32 = 1'b0;
    logic       bit_of = 1'b0;
    logic       pix_of = 1'b0;
    logic       state;
    logic [2:0] pixel_index;
    logic       frame_done;
    logic       run_clear;
`ifdef ANTON_NEOPIXEL_FRAME_COUNT_EN
    logic [15:0] frame_count;
`endif

    int total = 0;
    int bad = 0;
    int fd_cnt = 0;
    int n;

    typedef struct packed {
        logic       st;
        logic [2:0] idx;
    } exp_t;

    exp_t       sb[$];
    logic [2:0] model_idx;

    anton_neopixel_stream_seq #(
        .BUFFER_END   (BE),
        .RESET_CYCLES (RC)
    ) dut (
        .clk7mhz         (clk7mhz),
        .rst             (rst),
        .reg_ctrl_init   (init),
        .reg_ctrl_run    (run),
        .reg_ctrl_loop   (loop_en),
        .reg_ctrl_32bit  (m32),
        .stream_bit_of   (bit_of),
        .stream_pixel_of (pix_of),
        .state           (state),
`ifdef ANTON_NEOPIXEL_FRAME_COUNT_EN
        .frame_count     (frame_count),
`endif
        .pixel_index     (pixel_index),
        .frame_done      (frame_done),
        .run_clear       (run_clear)
    );

    always #71 clk7mhz = ~clk7mhz;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk7mhz);
        @(negedge clk7mhz);
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) begin
            tick();
            if (frame_done) fd_cnt++;
        end
    endtask

    task automatic wait_done(input int limit, output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (frame_done !== 1'b1 && cnt < limit);
    endtask

    task automatic wait_tx(input int limit, output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (state !== 1'b1 && cnt < limit);
        model_idx = 3'd0;
    endtask

    // one stream_bit_of strobe; expected outcome queued now, scored after the edge
    task automatic pulse(input logic last, input logic w32);
        exp_t e;
        exp_t g;
        m32    = w32;
        bit_of = 1'b1;
        pix_of = last;
        if (last) begin
            e.st  = 1'b0;
            e.idx = 3'd0;
        end else begin
            e.st  = 1'b1;
            e.idx = w32 ? ((model_idx & 3'b100) + 3'd4) : (model_idx + 3'd1);
        end
        sb.push_back(e);
        tick();
        bit_of = 1'b0;
        pix_of = 1'b0;
        g = sb.pop_front();
        chk("adv_state", {31'd0, state}, {31'd0, g.st});
        chk("adv_index", {29'd0, pixel_index}, {29'd0, g.idx});
        model_idx = g.idx;
    endtask

    initial begin
        model_idx = 3'd0;
        idle(2);
        chk("rst_state", {31'd0, state}, 32'd0);
        chk("rst_index", {29'd0, pixel_index}, 32'd0);
        chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
        chk("rst_run_clear", {31'd0, run_clear}, 32'd0);
        rst = 1'b0;

        // single frame, no loop: one latch period then run_clear
        run = 1'b1;
        loop_en = 1'b0;
        wait_done(1000, n);
        chk("single_latch_len", n, RC);
        chk("single_run_clear", {31'd0, run_clear}, 32'd1);
        chk("single_state", {31'd0, state}, 32'd0);
        run = 1'b0;
        tick();
        chk("single_fd_once", {31'd0, frame_done}, 32'd0);
        chk("single_rc_once", {31'd0, run_clear}, 32'd0);

        // looping frames
        rst = 1'b1;
        tick();
        rst = 1'b0;
        loop_en = 1'b1;
        run = 1'b1;
        wait_tx(1000, n);
        chk("loop_first_tx", n, RC);
        chk("loop_first_fd", {31'd0, frame_done}, 32'd1);
        chk("loop_no_run_clear", {31'd0, run_clear}, 32'd0);
        chk("loop_first_index", {29'd0, pixel_index}, 32'd0);

        for (int p = 0; p <= BE; p++) begin
            idle(191);
            chk("hold_index", {29'd0, pixel_index}, p);
            pulse(p == BE, 1'b0);
        end

        wait_tx(1000, n);
        chk("loop_tx2", n, RC);
        idle(191);
        pulse(1'b0, 1'b1);
        idle(191);
        pulse(1'b1, 1'b1);

        wait_tx(1000, n);
        chk("loop_tx3", n, RC);
`ifdef ANTON_NEOPIXEL_FRAME_COUNT_EN
        chk("frame_count", {16'd0, frame_count}, 32'd3);
`endif

        // mode toggles mid-frame: 0 -> 1 (8-bit) -> 4 (32-bit realign) -> 5 (8-bit)
        pulse(1'b0, 1'b0);
        pulse(1'b0, 1'b1);
        pulse(1'b0, 1'b0);
        chk("pre_init_index", {29'd0, pixel_index}, 32'd5);

        init = 1'b1;
        tick();
        init = 1'b0;
        chk("init_state", {31'd0, state}, 32'd0);
        chk("init_index", {29'd0, pixel_index}, 32'd0);
        chk("init_no_fd", {31'd0, frame_done}, 32'd0);

        // pause run mid-latch at count 200 for 50 cycles
        fd_cnt = 0;
        idle(200);
        run = 1'b0;
        idle(50);
        chk("pause_no_fd", fd_cnt, 0);
        chk("pause_state", {31'd0, state}, 32'd0);
        run = 1'b1;
        wait_done(1000, n);
        chk("pause_late_done", n, RC - 200);
        chk("pause_then_tx", {31'd0, state}, 32'd1);
        model_idx = 3'd0;

        // synchronous reset mid-frame aborts without frame_done
        pulse(1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_state", {31'd0, state}, 32'd0);
        chk("abort_index", {29'd0, pixel_index}, 32'd0);
        chk("abort_no_fd", {31'd0, frame_done}, 32'd0);
        fd_cnt = 0;
        idle(5);
        chk("abort_quiet", fd_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
